// File: rtl/decade_counter_core_if.sv
// count_ifc: bundle between a driver block and a decade_counter_core stage.
// The driver owns P, Load, Enable (and Up); the counter owns Q, TC and RCO.
// Optional macro DECADE_COUNTER_UPDOWN_EN adds the Up direction signal.
//   Load   : parallel load request        (driver -> counter)
//   Enable : count enable                 (driver -> counter)
//   P      : parallel load value, WIDTH   (driver -> counter)
//   Up     : 1 = count up, 0 = count down (driver -> counter, macro only)
//   Q      : registered count, WIDTH      (counter -> driver)
//   TC     : terminal count               (counter -> driver)
//   RCO    : ripple carry to next stage   (counter -> driver)
// Modports: master = driver side; slave and dut = counter side.
interface count_ifc #(
    parameter int unsigned WIDTH = 4
);
    logic             Load;
    logic             Enable;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             RCO;
`ifdef DECADE_COUNTER_UPDOWN_EN
    logic             Up;

    modport master (output Load, Enable, P, Up, input Q, TC, RCO);
    modport slave  (input Load, Enable, P, Up, output Q, TC, RCO);
    modport dut    (input Load, Enable, P, Up, output Q, TC, RCO);
`else
    modport master (output Load, Enable, P, input Q, TC, RCO);
    modport slave  (input Load, Enable, P, output Q, TC, RCO);
    modport dut    (input Load, Enable, P, output Q, TC, RCO);
`endif
endinterface

// File: rtl/decade_counter_core.sv
// decade_counter_core: synchronous modulo-MODULUS counter (default 0..9) with
// parallel load, count enable, terminal count and ripple carry, used as a BCD
// digit stage. Stages cascade by feeding RCO into the next stage's Enable.
// Optional macro DECADE_COUNTER_UPDOWN_EN enables down counting via bus.Up.
// Ports:
//   CLK : clock, all state updates on the rising edge
//   MR  : master reset, synchronous, active-high (Q <= 0)
//   bus : count_ifc dut modport (Load, Enable, P, [Up] in; Q, TC, RCO out)
// Parameters: WIDTH (bits of P/Q), MODULUS (2..2^WIDTH).
// Edge priority: MR, then Load, then Enable, otherwise hold.
module decade_counter_core #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input logic   CLK,
    input logic   MR,
    count_ifc.dut bus
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_up;
    logic             w_tc;

    // Direction select; the up-only build behaves as Up tied high.
`ifdef DECADE_COUNTER_UPDOWN_EN
    assign w_up = bus.Up;
`else
    assign w_up = 1'b1;
`endif

    // Next count for the non-reset case; unknown controls fall to hold.
    always_comb begin
        w_q_next = r_q;
        if (bus.Load) begin
            w_q_next = bus.P;
        end else if (bus.Enable) begin
            if (w_up) begin
                // Out-of-range loaded values wrap to 0 like the terminal value.
                if (r_q >= LAST) w_q_next = '0;
                else             w_q_next = r_q + 1'b1;
            end else begin
                // Out-of-range values re-enter the range at the top.
                if ((r_q == '0) || (r_q > LAST)) w_q_next = LAST;
                else                             w_q_next = r_q - 1'b1;
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (MR) r_q <= '0;
        else    r_q <= w_q_next;
    end

    // Terminal count follows direction; RCO only when this edge will wrap.
    assign w_tc    = w_up ? (r_q == LAST) : (r_q == '0);
    assign bus.Q   = r_q;
    assign bus.TC  = w_tc;
    assign bus.RCO = w_tc & bus.Enable & ~bus.Load & ~MR;

endmodule

// File: tb/tb_decade_counter_core.sv
// Bench for decade_counter_core: directed vector table, hand-written corner
// sequences, then random stimulus checked against an arithmetic model.
module tb_decade_counter_core;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned MODULUS = 10;

    logic clk;
    logic mr;

    count_ifc #(.WIDTH(WIDTH)) u_if ();

    decade_counter_core #(
        .WIDTH  (WIDTH),
        .MODULUS(MODULUS)
    ) u_dut (
        .CLK(clk),
        .MR (mr),
        .bus(u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    typedef struct {
        logic       mr;
        logic       ld;
        logic       en;
        logic [3:0] p;
        logic       chk_pre; // compare TC/RCO before the edge
        logic       tc;
        logic       rco;
        int         q;       // Q after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic m, logic l, logic e, int p, logic cp,
                                logic tc, logic rco, int q);
        vec_t v;
        v.mr = m; v.ld = l; v.en = e; v.p = 4'(p);
        v.chk_pre = cp; v.tc = tc; v.rco = rco; v.q = q;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic m, input logic l, input logic e,
                         input logic [3:0] p, input logic up);
        mr = m; u_if.Load = l; u_if.Enable = e; u_if.P = p;
`ifdef DECADE_COUNTER_UPDOWN_EN
        u_if.Up = up;
`else
        if (up !== 1'b1) $display("note: down request ignored in up-only build");
`endif
    endtask

    // Behavioural model: the counter's value and rules in plain integers.
    int  mq;
    function automatic int model_next(int q, logic m, logic l, logic e,
                                      int p, logic up);
        if (m) return 0;
        if (l) return p;
        if (!e) return q;
        if (up) return (q + 1 < MODULUS) ? q + 1 : 0;
        if (q == 0 || q >= MODULUS) return MODULUS - 1;
        return q - 1;
    endfunction

    function automatic int model_tc(int q, logic up);
        return up ? int'(q == MODULUS - 1) : int'(q == 0);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        // ---- Directed table (up direction) ----
        vecs.push_back(mk(1,0,1, 7, 0,0,0, 0));   // reset with Enable high
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 1));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 2));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 3));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 4));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 5));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 6));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 7));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 8));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 9));
        vecs.push_back(mk(0,0,1, 0, 1,1,1, 0));   // 9 -> 0, TC and RCO high
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 1));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 2));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 3));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 4));
        vecs.push_back(mk(0,0,0, 0, 1,0,0, 4));   // hold
        vecs.push_back(mk(0,0,0, 0, 1,0,0, 4));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 5));
        vecs.push_back(mk(0,1,1, 7, 1,0,0, 7));   // load beats enable
        vecs.push_back(mk(0,1,0,12, 1,0,0,12));   // out-of-range load
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 0));   // 12 -> 0
        vecs.push_back(mk(0,1,0, 9, 1,0,0, 9));
        vecs.push_back(mk(0,1,1, 3, 1,1,0, 3));   // TC high, Load blocks RCO
        vecs.push_back(mk(0,1,0, 9, 1,0,0, 9));
        vecs.push_back(mk(1,0,1, 0, 1,1,0, 0));   // TC high, MR blocks RCO
        vecs.push_back(mk(0,1,0, 5, 1,0,0, 5));
        vecs.push_back(mk(1,1,1, 7, 1,0,0, 0));   // MR beats Load
        vecs.push_back(mk(0,1,0,15, 1,0,0,15));
        vecs.push_back(mk(0,0,1, 0, 1,0,0, 0));   // 15 -> 0

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].mr, vecs[i].ld, vecs[i].en, vecs[i].p, 1'b1);
            #2;
            if (vecs[i].chk_pre) begin
                check($sformatf("vec%0d_tc", i),  int'(u_if.TC),  int'(vecs[i].tc));
                check($sformatf("vec%0d_rco", i), int'(u_if.RCO), int'(vecs[i].rco));
            end
            @(posedge clk); #1;
            check($sformatf("vec%0d_q", i), int'(u_if.Q), vecs[i].q);
        end
        check("post_vec_tc", int'(u_if.TC), 0);

        // ---- MR without a clock edge must not clear Q ----
        drive(1'b0, 1'b1, 1'b0, 4'd6, 1'b1);
        @(posedge clk); #1;
        check("ld6_q", int'(u_if.Q), 6);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        #3;
        check("mr_no_edge_q", int'(u_if.Q), 6);
        check("mr_no_edge_rco", int'(u_if.RCO), 0);
        @(posedge clk); #1;
        check("mr_edge_q", int'(u_if.Q), 0);
        check("reset_tc", int'(u_if.TC), 0);
        check("reset_rco", int'(u_if.RCO), 0);

`ifdef DECADE_COUNTER_UPDOWN_EN
        // ---- Down counting: 1 -> 0 -> 9 -> 8, out-of-range re-entry ----
        drive(1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
        @(posedge clk); #1;
        check("dn_ld1_q", int'(u_if.Q), 1);
        check("dn_q1_tc", int'(u_if.TC), 0);
        drive(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        @(posedge clk); #1;
        check("dn_q0", int'(u_if.Q), 0);
        check("dn_q0_tc", int'(u_if.TC), 1);
        check("dn_q0_rco", int'(u_if.RCO), 1);
        u_if.Up = 1'b1; #1;
        check("dir_change_tc", int'(u_if.TC), 0);
        u_if.Up = 1'b0; #1;
        @(posedge clk); #1;
        check("dn_q9", int'(u_if.Q), 9);
        check("dn_q9_tc", int'(u_if.TC), 0);
        @(posedge clk); #1;
        check("dn_q8", int'(u_if.Q), 8);
        drive(1'b0, 1'b1, 1'b0, 4'd12, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        @(posedge clk); #1;
        check("dn_oor_q", int'(u_if.Q), 9);
`endif

        // ---- Random stimulus vs. model ----
        mq = -1;
        for (int n = 0; n < 400; n++) begin
            logic m, l, e, up;
            int   p;
            m  = (n == 0) || ($urandom_range(0, 19) == 0);
            l  = ($urandom_range(0, 5) == 0);
            e  = ($urandom_range(0, 3) != 0);
            p  = int'($urandom_range(0, 15));
`ifdef DECADE_COUNTER_UPDOWN_EN
            up = ($urandom_range(0, 2) != 0);
`else
            up = 1'b1;
`endif
            drive(m, l, e, 4'(p), up);
            #2;
            if (mq >= 0) begin
                check("rnd_tc", int'(u_if.TC), model_tc(mq, up));
                check("rnd_rco", int'(u_if.RCO),
                      model_tc(mq, up) & int'(e & ~l & ~m));
            end
            mq = model_next(mq, m, l, e, p, up);
            @(posedge clk); #1;
            check("rnd_q", int'(u_if.Q), mq);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
